// File: rtl/seq_gen_if.sv
// Handshake bundle between a sequence-generator master (stimulus side) and seq_gen.
// Carries the start/pattern/repeat request and the serial dout/valid/busy/done response.
interface seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (output start, pattern, repeat_n, input dout, valid, busy, done);
  modport slave  (input start, pattern, repeat_n, output dout, valid, busy, done);
endinterface

// File: rtl/seq_gen.sv
// Serial frame generator: sends a captured pattern MSB first, repeated N times, then pulses done.
// Optional even-parity bit after every frame when SEQ_GEN_PARITY_EN is defined.
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_gen_if.slave  bus
);

  localparam int               BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [WIDTH-1:0] shadow_r, shadow_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [CNT_W-1:0] frame_cnt_r, frame_cnt_s;
  logic             dout_r, dout_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state, datapath and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    shadow_s    = shadow_r;
    bit_cnt_s   = bit_cnt_r;
    frame_cnt_s = frame_cnt_r;
    dout_s      = 1'b0;
    valid_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          shadow_s    = bus.pattern;
          shift_s     = bus.pattern;
          bit_cnt_s   = {BW{1'b0}};
          frame_cnt_s = (bus.repeat_n == {CNT_W{1'b0}}) ? CNT_ONE : bus.repeat_n;
          state_s     = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r != LAST_BIT) begin
          shift_s   = {shift_r[WIDTH-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r + BW'(1);
        end
`ifdef SEQ_GEN_PARITY_EN
        else begin
          state_s = PAR;
        end
`else
        // Frame boundary: reload with no gap while frames remain.
        else if (frame_cnt_r > CNT_ONE) begin
          frame_cnt_s = frame_cnt_r - CNT_ONE;
          shift_s     = shadow_r;
          bit_cnt_s   = {BW{1'b0}};
          state_s     = SHIFT;
        end else begin
          state_s = DONE;
        end
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        if (frame_cnt_r > CNT_ONE) begin
          frame_cnt_s = frame_cnt_r - CNT_ONE;
          shift_s     = shadow_r;
          bit_cnt_s   = {BW{1'b0}};
          state_s     = SHIFT;
        end else begin
          state_s = DONE;
        end
      end
`endif
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      SHIFT: begin
        dout_s  = shift_s[WIDTH-1];
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        dout_s  = even_parity(shadow_s);
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
`endif
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= {WIDTH{1'b0}};
      shadow_r    <= {WIDTH{1'b0}};
      bit_cnt_r   <= {BW{1'b0}};
      frame_cnt_r <= {CNT_W{1'b0}};
      dout_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      shadow_r    <= shadow_s;
      bit_cnt_r   <= bit_cnt_s;
      frame_cnt_r <= frame_cnt_s;
      dout_r      <= dout_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign bus.dout  = dout_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_seq_gen.sv
// Directed, table-driven bench for seq_gen (WIDTH=8, CNT_W=4); honours SEQ_GEN_PARITY_EN.
module tb_seq_gen;

  localparam int W = 8;
`ifdef SEQ_GEN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [7:0] pat;
    logic [3:0] rn;
    int         n_eff;
    logic       par;
    int         busy_np;
    int         busy_p;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[5];

  seq_gen_if #(.WIDTH(8), .CNT_W(4)) bus ();

  seq_gen #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: start, scramble inputs after capture, re-pulse start in the 3rd bit.
  task automatic run_xfer(input int id, input logic [7:0] pat, input logic [3:0] rn,
                          input int n_eff, input logic par, input int exp_busy);
    int   vcnt;
    int   bcnt;
    int   dcnt;
    int   pos;
    logic last_done;
    logic exp_bit;
    vcnt = 0;
    bcnt = 0;
    dcnt = 0;
    last_done = 1'b0;
    bus.pattern  = pat;
    bus.repeat_n = rn;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.pattern  = ~pat;
    bus.repeat_n = 4'd15;
    for (int cyc = 0; cyc < 300 && bus.busy; cyc++) begin
      if (cyc == 2) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
      end else if (cyc == 3) begin
        bus.start = 1'b0;
      end
      if (bus.valid) begin
        pos     = vcnt % (W + P);
        exp_bit = (pos < W) ? pat[W-1-pos] : par;
        check($sformatf("v%0d dout bit %0d", id, vcnt), bus.dout, exp_bit);
        vcnt++;
      end else begin
        check($sformatf("v%0d dout low when not valid", id), bus.dout, 1'b0);
      end
      if (bus.done) dcnt++;
      last_done = bus.done;
      bcnt++;
      tick();
    end
    bus.start = 1'b0;
    check($sformatf("v%0d busy cycles", id), bcnt, exp_busy);
    check($sformatf("v%0d valid bits", id), vcnt, n_eff * (W + P));
    check($sformatf("v%0d done pulses", id), dcnt, 1);
    check($sformatf("v%0d done in last busy cycle", id), last_done, 1'b1);
    check($sformatf("v%0d busy released", id), bus.busy, 1'b0);
    repeat (3) begin
      tick();
      check($sformatf("v%0d no queued transfer", id), bus.busy, 1'b0);
    end
  endtask

  initial begin
    int bcnt;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{8'hB4, 4'd1,  1,  1'b0, 9,   10};
    vecs[1] = '{8'hA5, 4'd3,  3,  1'b0, 25,  28};
    vecs[2] = '{8'h3C, 4'd0,  1,  1'b0, 9,   10};
    vecs[3] = '{8'h07, 4'd2,  2,  1'b1, 17,  19};
    vecs[4] = '{8'hF0, 4'd15, 15, 1'b0, 121, 136};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.pattern  = 8'h00;
    bus.repeat_n = 4'd0;
    repeat (2) tick();
    check("reset dout",  bus.dout,  1'b0);
    check("reset valid", bus.valid, 1'b0);
    check("reset busy",  bus.busy,  1'b0);
    check("reset done",  bus.done,  1'b0);

    // Release reset; the first vector's start meets the very next edge.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_xfer(i, vecs[i].pat, vecs[i].rn, vecs[i].n_eff, vecs[i].par,
               (P == 1) ? vecs[i].busy_p : vecs[i].busy_np);
    end

    // Reset during the 4th bit aborts the transfer.
    bus.pattern  = 8'h5A;
    bus.repeat_n = 4'd1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("abort 4th bit valid", bus.valid, 1'b1);
    check("abort 4th bit dout",  bus.dout,  1'b1);
    rst = 1'b1;
    #1;
    check("abort async dout",  bus.dout,  1'b0);
    check("abort async valid", bus.valid, 1'b0);
    check("abort async busy",  bus.busy,  1'b0);
    check("abort async done",  bus.done,  1'b0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("abort no done", bus.done, 1'b0);
      check("abort stays idle", bus.busy, 1'b0);
    end
    run_xfer(5, 8'h81, 4'd1, 1, 1'b0, (P == 1) ? 10 : 9);

    // start held high: exactly one idle cycle between back-to-back transfers.
    bus.pattern  = 8'hC3;
    bus.repeat_n = 4'd1;
    bus.start    = 1'b1;
    tick();
    bcnt = 0;
    for (int cyc = 0; cyc < 50 && bus.busy; cyc++) begin
      bcnt++;
      tick();
    end
    check("held start busy cycles", bcnt, (P == 1) ? 10 : 9);
    check("held start idle gap", bus.busy, 1'b0);
    tick();
    check("held start restart busy",  bus.busy,  1'b1);
    check("held start restart valid", bus.valid, 1'b1);
    check("held start restart dout",  bus.dout,  1'b1);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 50 && bus.busy; cyc++) begin
      tick();
    end
    check("held start drained", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter WIDTH, 8, number of bits per frame (pattern length), WIDTH >= 2.
REQ-002 Parameter CNT_W, 4, width of the frame repeat count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  frame bits, sent MSB first.
REQ-007 repeat_n  input  CNT_W  number of back-to-back frames; 0 is treated as 1.
REQ-008 dout  output  1  serial bit stream feeding the sequence detector's d input.
REQ-009 valid  output  1  high while dout carries a frame or parity bit.
REQ-010 busy  output  1  high from the cycle after start capture until IDLE is re-entered.
REQ-011 done  output  1  one-cycle pulse after the last bit of the last frame.

Function
REQ-012 Moore FSM states: IDLE, SHIFT, PAR (present only with SEQ_GEN_PARITY_EN), DONE; all outputs decoded from registered state and registers only, with no combinational input-to-output path.
REQ-013 IDLE: on a clock edge with start=1, capture pattern into a shadow register, capture max(repeat_n,1) into the frame counter, load the shift register, and go to SHIFT.
REQ-014 Latency: the first bit (pattern[WIDTH-1]) appears on dout with valid=1 in the cycle immediately after the capture edge.
REQ-015 SHIFT: emit one bit per cycle, MSB first, using a bit counter of width ceil(log2(WIDTH)); after WIDTH bits, go to PAR if compiled in, otherwise go to end-of-frame.
REQ-016 End-of-frame: if frames remaining > 1, decrement the counter, reload the shift register from the shadow register, and stay in SHIFT with no idle gap; otherwise go to DONE.
REQ-017 DONE lasts exactly one cycle with done=1, valid=0, dout=0, busy=1, then goes to IDLE.
REQ-018 dout is 0 whenever valid=0.
REQ-019 start while not in IDLE (including DONE) is ignored, and no request is queued.
REQ-020 Changes to pattern or repeat_n after capture have no effect on the transfer in progress.
REQ-021 Busy duration per transfer = N*(WIDTH+P)+1 cycles, where N = max(repeat_n,1) and P = 1 if parity is compiled in, else 0.
REQ-022 start=1 held continuously starts a new transfer on the first edge after DONE returns to IDLE, i.e. one idle cycle between transfers.

Reset
REQ-023 While rst=1, outputs are immediately (asynchronously) dout=0, valid=0, busy=0, done=0; state=IDLE; all counters and registers are 0.
REQ-024 Reset asserted mid-transfer aborts it with no done pulse; after release, the block waits for a new start.
REQ-025 start coincident with the first edge after rst deasserts is honoured normally.

Configuration
REQ-026 Macro SEQ_GEN_PARITY_EN: when defined, each frame is followed by one PAR cycle with valid=1 and dout = XOR of all shadow pattern bits (even parity).
REQ-027 When SEQ_GEN_PARITY_EN is not defined, the PAR state and its logic are absent and frames are WIDTH bits long.

Verification (WIDTH=8, CNT_W=4)
REQ-028 Scenario: start with pattern=8'hB4, repeat_n=1 -> dout 1,0,1,1,0,1,0,0 on 8 consecutive valid cycles, then done=1 for one cycle, then busy=0.
REQ-029 Scenario: pattern=8'hA5, repeat_n=3 -> 24 contiguous valid bits repeating 10100101, a single done pulse, and busy high for 25 cycles.
REQ-030 Scenario: repeat_n=0 with pattern=8'h3C -> identical to repeat_n=1: 8 bits 00111100 and one done pulse.
REQ-031 Scenario: start pulsed and pattern changed to 8'hFF during the 3rd bit -> stream unchanged and no second transfer follows.
REQ-032 Scenario: rst asserted during the 4th bit -> dout, valid and busy go to 0 before the next edge, no done pulse; a later start with 8'h81 sends 10000001 correctly.
REQ-033 Scenario: with SEQ_GEN_PARITY_EN defined, 8'hB4 -> 9th bit 0, and 8'h07 -> 9th bit 1; busy lasts 10 cycles for repeat_n=1.
